pipe_stage_ctrl: RTL and testbench

Parametrised pipeline sequencing controller for the multi-stage processor. It generalises the fixed four-stage fill/branch/stop control to STAGES stages, a configurable branch-resolve stage, and an external stall. It produces per-stage IR load strobes, per-stage enables, the branch-taken redirect, and a sticky halt flag for the performance counter. It sits beside the datapath, reading every stage's instruction register and the N/Z flags.

---
 rtl/pipe_stage_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencing controller: fill/flush of STAGES stages, branch redirect, stop halt.
// Optional taken-branch counter is built when PIPE_STAGE_CTRL_BRANCH_STATS_EN is defined.
module pipe_stage_ctrl #(
    parameter int STAGES   = 4,
    parameter int IRW      = 8,
    parameter int BR_STAGE = 2,
    parameter int CNTW     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    N,
    input  logic                    Z,
    input  logic                    stall,
    input  logic [STAGES*IRW-1:0]   ir_bus,
    output logic [STAGES-1:0]       ir_load,
    output logic [STAGES-1:0]       stage_en,
    output logic                    branch,
    output logic                    halted,
    output logic [CNTW-1:0]         branch_count
);

    localparam int             FW       = $clog2(STAGES);
    localparam logic [FW-1:0]  FILL_MAX = FW'(STAGES - 1);

    typedef enum logic [3:0] {
        OP_LOAD  = 4'd0,
        OP_STOP  = 4'd1,
        OP_STORE = 4'd2,
        OP_BZ    = 4'd5,
        OP_BNZ   = 4'd9,
        OP_NOP   = 4'd10,
        OP_BPZ   = 4'd13
    } opcode_e;

    logic [3:0]    opcode [STAGES];
    logic [3:0]    br_op;
    logic          br_is_branch;
    logic          br_taken;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_next;
    logic          unused_ir_bits;

    // Only the opcode nibble of each IR is decoded here; the operand bits pass through the datapath.
    assign unused_ir_bits = ^ir_bus;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            opcode[k] = ir_bus[k*IRW +: 4];
        end
    end

    assign br_op        = opcode[BR_STAGE];
    assign br_is_branch = (br_op == OP_BZ) || (br_op == OP_BNZ) || (br_op == OP_BPZ);

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        br_taken = 1'b0;
        case (br_op)
            OP_BPZ:  br_taken = ~N;
            OP_BZ:   br_taken = Z;
            OP_BNZ:  br_taken = ~Z;
            default: br_taken = 1'b0;
        endcase
    end

    assign branch = br_taken && !stall && !reset && stage_en[BR_STAGE];

    // State register for the fill counter.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            fill <= '0;
        end else begin
            fill <= fill_next;
        end
    end

    // Next-state: a taken branch flushes, a stall holds, otherwise fill saturates upward.
    always_comb begin
        fill_next = fill;
        if (branch) begin
            fill_next = '0;
        end else if (!stall && fill != FILL_MAX) begin
            fill_next = fill + FW'(1);
        end
    end

    // Output decode of the fill state.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_en[k] = (int'(fill) >= k);
        end
    end

    always_comb begin
        ir_load = '0;
        if (reset) begin
            ir_load = '1;
        end else if (stall) begin
            ir_load = '0;
        end else if (br_is_branch) begin
            ir_load = '1;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                ir_load[k] = (opcode[k] != OP_STOP);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (opcode[STAGES-1] == OP_STOP && stage_en[STAGES-1]) begin
            halted <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_CTRL_BRANCH_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            branch_count <= '0;
        end else if (branch && branch_count != '1) begin
            branch_count <= branch_count + CNTW'(1);
        end
    end
`else
    assign branch_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed scenarios followed by randomized cycles
// checked against a behavioural model of fill/branch/halt/count rules.
module tb_pipe_stage_ctrl;

    localparam int STAGES   = 4;
    localparam int IRW      = 8;
    localparam int BR_STAGE = 2;
    localparam int CNTW     = 16;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  N;
    logic                  Z;
    logic                  stall;
    logic [STAGES*IRW-1:0] ir_bus;
    logic [STAGES-1:0]     ir_load;
    logic [STAGES-1:0]     stage_en;
    logic                  branch;
    logic                  halted;
    logic [CNTW-1:0]       branch_count;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int m_fill   = 0;
    bit m_halted = 1'b0;
    int m_count  = 0;

    pipe_stage_ctrl #(
        .STAGES   (STAGES),
        .IRW      (IRW),
        .BR_STAGE (BR_STAGE),
        .CNTW     (CNTW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .N            (N),
        .Z            (Z),
        .stall        (stall),
        .ir_bus       (ir_bus),
        .ir_load      (ir_load),
        .stage_en     (stage_en),
        .branch       (branch),
        .halted       (halted),
        .branch_count (branch_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] m_op(input int k);
        return ir_bus[k*IRW +: 4];
    endfunction

    function automatic bit m_is_branch_op(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd9) || (op == 4'd13);
    endfunction

    function automatic bit m_branch();
        logic [3:0] op;
        bit taken;
        op    = m_op(BR_STAGE);
        taken = (op == 4'd13 && !N) || (op == 4'd5 && Z) || (op == 4'd9 && !Z);
        return taken && !stall && !reset && (m_fill >= BR_STAGE);
    endfunction

    function automatic logic [STAGES-1:0] m_ir_load();
        logic [STAGES-1:0] v;
        if (reset) return '1;
        if (stall) return '0;
        if (m_is_branch_op(m_op(BR_STAGE))) return '1;
        for (int k = 0; k < STAGES; k++) v[k] = (m_op(k) != 4'd1);
        return v;
    endfunction

    function automatic logic [STAGES-1:0] m_stage_en();
        logic [STAGES-1:0] v;
        for (int k = 0; k < STAGES; k++) v[k] = (m_fill >= k);
        return v;
    endfunction

    // Opcodes in the low nibble, random filler in the operand bits.
    task automatic set_ops(input logic [3:0] o3, input logic [3:0] o2,
                           input logic [3:0] o1, input logic [3:0] o0);
        ir_bus = {4'($urandom), o3, 4'($urandom), o2, 4'($urandom), o1, 4'($urandom), o0};
    endtask

    task automatic check_comb(input string tag);
        #1;
        check({tag, ".ir_load"}, 32'(ir_load), 32'(m_ir_load()));
        check({tag, ".branch"},  32'(branch),  32'(m_branch()));
    endtask

    // Advance one edge, update the model from pre-edge inputs, then check registered outputs.
    task automatic tick(input string tag);
        bit b;
        bit stop_wb;
        b       = m_branch();
        stop_wb = (m_op(STAGES-1) == 4'd1) && (m_fill >= STAGES-1);
        @(posedge clock);
        if (reset) begin
            m_fill   = 0;
            m_halted = 1'b0;
            m_count  = 0;
        end else begin
            if (b) m_fill = 0;
            else if (!stall && m_fill < STAGES-1) m_fill = m_fill + 1;
            if (stop_wb) m_halted = 1'b1;
`ifdef PIPE_STAGE_CTRL_BRANCH_STATS_EN
            if (b && m_count < (1 << CNTW) - 1) m_count = m_count + 1;
`endif
        end
        #1;
        check({tag, ".stage_en"},     32'(stage_en),     32'(m_stage_en()));
        check({tag, ".halted"},       32'(halted),       32'(m_halted));
        check({tag, ".branch_count"}, 32'(branch_count), 32'(m_count));
    endtask

    initial begin
        logic [3:0] ops [7];
        int exp_cnt;
        ops = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd9, 4'd10, 4'd13};
`ifdef PIPE_STAGE_CTRL_BRANCH_STATS_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif

        // Reset
        reset = 1'b1; stall = 1'b0; N = 1'b0; Z = 1'b0;
        set_ops(4'd10, 4'd10, 4'd10, 4'd10);
        check_comb("reset");
        check("reset.ir_load_all1", 32'(ir_load), 32'hF);
        tick("reset");
        check("reset.stage_en", 32'(stage_en), 32'h1);
        check("reset.halted", 32'(halted), 32'h0);
        check("reset.count", 32'(branch_count), 32'h0);

        // Fill
        reset = 1'b0;
        check_comb("fill0");
        tick("fill1"); check("fill.e1", 32'(stage_en), 32'h3);
        tick("fill2"); check("fill.e2", 32'(stage_en), 32'h7);
        tick("fill3"); check("fill.e3", 32'(stage_en), 32'hF);
        tick("fill4"); check("fill.hold", 32'(stage_en), 32'hF);

        // Taken branch: bz with Z=1
        set_ops(4'd10, 4'd5, 4'd10, 4'd10); Z = 1'b1;
        check_comb("taken");
        check("taken.branch", 32'(branch), 32'h1);
        check("taken.ir_load", 32'(ir_load), 32'hF);
        tick("taken");
        check("taken.flush", 32'(stage_en), 32'h1);
        check("taken.count", 32'(branch_count), 32'(exp_cnt));

        // Refill
        set_ops(4'd10, 4'd10, 4'd10, 4'd10); Z = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_comb("refill");
            tick("refill");
        end
        check("refill.full", 32'(stage_en), 32'hF);

        // Untaken branch: bpz with N=1
        set_ops(4'd10, 4'd13, 4'd10, 4'd10); N = 1'b1;
        check_comb("untaken");
        check("untaken.branch", 32'(branch), 32'h0);
        check("untaken.ir_load", 32'(ir_load), 32'hF);
        tick("untaken");
        check("untaken.stage_en", 32'(stage_en), 32'hF);
        N = 1'b0;

        // Stop moving toward writeback
        set_ops(4'd10, 4'd10, 4'd1, 4'd10);
        check_comb("stop1");
        check("stop1.ir_load", 32'(ir_load), 32'hD);
        tick("stop1");
        set_ops(4'd1, 4'd10, 4'd10, 4'd10);
        check_comb("stop3");
        check("stop3.ir_load", 32'(ir_load), 32'h7);
        tick("stop3");
        check("stop3.halted", 32'(halted), 32'h1);
        set_ops(4'd10, 4'd10, 4'd10, 4'd10);
        tick("halt_sticky1");
        tick("halt_sticky2");
        check("halt.sticky", 32'(halted), 32'h1);

        // Stall over a taken bnz
        set_ops(4'd10, 4'd9, 4'd10, 4'd10); Z = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_comb("stall");
            check("stall.branch", 32'(branch), 32'h0);
            check("stall.ir_load", 32'(ir_load), 32'h0);
            tick("stall");
            check("stall.hold", 32'(stage_en), 32'hF);
        end
        stall = 1'b0;
        check_comb("unstall");
        check("unstall.branch", 32'(branch), 32'h1);
        tick("unstall");
        check("unstall.flush", 32'(stage_en), 32'h1);

        // Reset mid-refill
        set_ops(4'd10, 4'd10, 4'd10, 4'd10);
        tick("prefill");
        check("prefill.stage_en", 32'(stage_en), 32'h3);
        reset = 1'b1;
        check_comb("midreset");
        tick("midreset");
        check("midreset.stage_en", 32'(stage_en), 32'h1);
        check("midreset.halted", 32'(halted), 32'h0);
        check("midreset.count", 32'(branch_count), 32'h0);
        reset = 1'b0;

        // Randomized cycles against the model
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            stall = ($urandom_range(0, 3) == 0);
            N     = 1'($urandom);
            Z     = 1'($urandom);
            set_ops(ops[$urandom_range(0, 6)], ops[$urandom_range(0, 6)],
                    ops[$urandom_range(0, 6)], ops[$urandom_range(0, 6)]);
            check_comb("rand");
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
